seq_adder: RTL and testbench

//   Parametrised multi-cycle add/subtract unit; next generation of the team's

---
 rtl/seq_adder_pkg.sv | 22 ++
 rtl/chunk_adder.sv | 23 ++
 rtl/seq_adder.sv | 106 ++++++++++
 tb/tb_seq_adder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle add/subtract unit.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Keep the index at least one bit wide so NCHUNK=1 still has a legal counter.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from per-bit full adders.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per cycle through a registered
// carry, with valid/ready handshakes on the operand and result sides.
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;
    int               shamt;

    assign shamt   = CHUNK * int'(idx);
    assign a_chunk = CHUNK'(a_reg >> shamt);
    assign b_chunk = CHUNK'(b_reg >> shamt);

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a   (a_chunk),
        .b   (b_chunk),
        .cin (carry),
        .s   (s_chunk),
        .cout(c_chunk)
    );

    // b_reg holds b already inverted for subtraction, so the chain only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= sub ? ~b : b;
                        carry    <= sub ? 1'b1 : cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum   <= (sum & ~(CHUNK_MASK << shamt)) | (WIDTH'(s_chunk) << shamt);
                    carry <= c_chunk;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout      <= c_chunk;
                        ovf       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (s_chunk[CHUNK-1] != a_reg[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_adder.sv
// Randomised and directed checks of seq_adder (32/8 and 8/8 configurations)
// against a plain-arithmetic reference model.
module tb_seq_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, sub, cout, ovf;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, sum8;
    logic        cin8, sub8, cout8, ovf8;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {ovf, cout, sum}; overflow judged by whether the signed result fits.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
        longint      sx, sy, r;
        logic [32:0] w;
        logic [31:0] s;
        logic        co, ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sb) begin
            r  = sx - sy;
            s  = x - y;
            co = (x >= y);
        end else begin
            r  = sx + sy + longint'(ci);
            w  = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            s  = w[31:0];
            co = w[32];
        end
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {ov, co, s};
    endfunction

    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic sb,
                                 input int holdCycles, input bit pulse);
        logic [33:0] exp;
        int          n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        exp = model(x, y, ci, sb);
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        tick();
        n = 0;
        while (!out_valid && n < 20) begin
            in_valid = 1'($urandom_range(1));
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
            tick();
            n++;
        end
        in_valid = 1'b0;
        checkOutput("latency", 64'(n), 64'd4);
        checkOutput("sum", 64'(sum), 64'(exp[31:0]));
        checkOutput("cout", 64'(cout), 64'(exp[32]));
        checkOutput("ovf", 64'(ovf), 64'(exp[33]));
        checkOutput("in_ready_busy", 64'(in_ready), 64'd0);
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = pulse; a = 32'd1; b = 32'd1; cin = 1'b0; sub = 1'b0;
            tick();
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_sum", 64'(sum), 64'(exp[31:0]));
            checkOutput("hold_cout", 64'(cout), 64'(exp[32]));
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("out_valid_drop", 64'(out_valid), 64'd0);
        checkOutput("in_ready_back", 64'(in_ready), 64'd1);
        if (pulse) begin
            tick();
            tick();
            checkOutput("no_ghost_op", 64'(out_valid), 64'd0);
            checkOutput("no_ghost_ready", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'd0);
        checkOutput("rst_cout", 64'(cout), 64'd0);
        checkOutput("rst_ovf", 64'(ovf), 64'd0);

        applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("wrap_sum", 64'(sum), 64'h0);
        applyStimulus(32'h5, 32'h7, 1'b1, 1'b1, 0, 1'b0);
        checkOutput("borrow_sum", 64'(sum), 64'hFFFF_FFFE);
        applyStimulus(32'h7, 32'h5, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(32'h8000_0000, 32'h1, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 3, 1'b1);

        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrun_rst_sum", 64'(sum), 64'd0);
        applyStimulus(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)),
                          $urandom_range(2), 1'($urandom_range(1)));
        end

        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("w8_latency", 64'(n), 64'd1);
        checkOutput("w8_sum", 64'(sum8), 64'h00);
        checkOutput("w8_cout", 64'(cout8), 64'd1);
        checkOutput("w8_ovf", 64'(ovf8), 64'd1);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        checkOutput("w8_in_ready", 64'(in_ready8), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
